bram_image_reader: RTL and testbench

- Drains a processed image from the result DPBRAM (the block that receives moved/Sobel-filtered data) over one BRAM port.
- Presents the image as a valid/ready pixel stream in address order 0..N-1, with a last flag on the final pixel.
- Sits between the Sobel top's result buffer and downstream consumers: file dump model, display, or DMA.
- Replaces direct hierarchical peeks into the BRAM array.

---
 rtl/sobel_pkg.sv | 14 +
 rtl/sync_fifo2.sv | 46 ++++
 rtl/bram_image_reader.sv | 145 ++++++++++++++
 tb/tb_bram_image_reader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel datapath: default BRAM geometry and the
// reader FSM state encoding.
package sobel_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with occupancy count; a push and a pop in the
// same cycle leave the occupancy unchanged.
module sync_fifo2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign w_pop   = i_pop & (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/bram_image_reader.sv
// Streams N pixels out of the result DPBRAM as a valid/ready stream with last.
// Optional running pixel sum enabled by BRAM_IMAGE_READER_CHECKSUM_EN.
//
// state  | meaning
// S_IDLE | waiting for i_start
// S_RUN  | issuing reads and streaming pixels out
// S_DONE | one-cycle completion pulse, then back to idle
module bram_image_reader
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int IMAGE_WIDTH  = 100,
  parameter int IMAGE_HEIGHT = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_num_cnt,
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ce,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready
`ifdef BRAM_IMAGE_READER_CHECKSUM_EN
  ,output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_checksum
`endif
);

  // A full default image must be expressible in the count width.
  if (IMAGE_WIDTH * IMAGE_HEIGHT >= (1 << ADDR_WIDTH)) begin : g_image_too_large
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_issue_cnt;
  logic [ADDR_WIDTH-1:0] r_accept_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ce_d;
  logic                  w_start_ok;
  logic                  w_issue;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_fifo_empty;
  logic [1:0]            w_fifo_cnt;
  logic [2:0]            w_slots_used;

  // A beat leaving this cycle frees its slot, which sustains one pixel/cycle.
  assign w_slots_used = 3'(w_fifo_cnt) + 3'(r_ce_d) - 3'(w_accept);
  assign w_issue      = (r_state == S_RUN) && (r_issue_cnt < r_count) &&
                        (w_slots_used < 3'd2);
  assign w_accept     = o_valid & i_ready;
  assign w_last       = (r_accept_cnt == r_count - ADDR_WIDTH'(1));

  assign o_ce    = w_issue;
  assign o_we    = 1'b0;
  assign o_addr  = w_issue ? r_issue_cnt : r_addr;
  assign o_valid = ~w_fifo_empty;
  assign o_last  = o_valid & w_last;

  sync_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_ce_d),
    .i_data (i_q),
    .i_pop  (w_accept),
    .o_data (o_data),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    o_idle      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_idle = 1'b1;
        if (i_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = (i_num_cnt != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_accept && o_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_issue_cnt  <= '0;
      r_accept_cnt <= '0;
      r_addr       <= '0;
      r_ce_d       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ce_d  <= w_issue;
      if (w_start_ok) begin
        r_count      <= i_num_cnt;
        r_issue_cnt  <= '0;
        r_accept_cnt <= '0;
      end
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + ADDR_WIDTH'(1);
        r_addr      <= r_issue_cnt;
      end
      if (w_accept) r_accept_cnt <= r_accept_cnt + ADDR_WIDTH'(1);
    end
  end

`ifdef BRAM_IMAGE_READER_CHECKSUM_EN
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] r_checksum;

  assign o_checksum = r_checksum;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + (DATA_WIDTH+ADDR_WIDTH)'(o_data);
    end
  end
`endif

endmodule

// File: tb/tb_bram_image_reader.sv
// Directed bench for bram_image_reader with a behavioural 1-cycle BRAM and a
// per-cycle stream scoreboard; checksum steps run when the macro is defined.
module tb_bram_image_reader;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_num_cnt;
  logic          o_idle, o_busy, o_done, o_ce, o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] i_q;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          i_ready;
`ifdef BRAM_IMAGE_READER_CHECKSUM_EN
  logic [DW+AW-1:0] o_checksum;
`endif

  always #5 clk = ~clk;

  bram_image_reader dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_num_cnt(i_num_cnt),
    .o_idle   (o_idle),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ce     (o_ce),
    .o_we     (o_we),
    .o_addr   (o_addr),
    .i_q      (i_q),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last),
    .i_ready  (i_ready)
`ifdef BRAM_IMAGE_READER_CHECKSUM_EN
    ,.o_checksum(o_checksum)
`endif
  );

  logic [DW-1:0] mem [0:65535];

  always @(posedge clk) if (o_ce) i_q <= mem[o_addr];

  int n_vec = 0, n_err = 0;
  int cyc = 0, n_ce = 0, n_acc = 0, cnt = 0, n_done = 0;
  int start_cyc = 0, first_valid_cyc = -1, done_cyc = 0;
  bit done_pending = 0, start_flag = 0, stall_prev = 0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sample one cycle's outputs against the model, then advance past the edge.
  task automatic step();
    bit nxt_done;
    #1;
    nxt_done = 0;
    chk("done", 32'(o_done), 32'(done_pending));
    if (o_done) begin n_done++; done_cyc = cyc; end
    if (o_ce) begin chk("addr", 32'(o_addr), 32'(n_ce)); n_ce++; end
    if (stall_prev) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data), 32'(prev_data));
    end
    if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_valid && i_ready && !rst) begin
      chk("data", 32'(o_data), 32'(mem[n_acc]));
      chk("last", 32'(o_last), 32'(n_acc == cnt - 1));
      if (n_acc == cnt - 1) nxt_done = 1;
      n_acc++;
    end
    chk("ahead", 32'(n_ce - n_acc <= 2), 32'd1);
    if (start_flag && cnt == 0) nxt_done = 1;
    stall_prev   = o_valid && !i_ready && !rst;
    prev_data    = o_data;
    done_pending = nxt_done && !rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start(input int n);
    i_start = 1; i_num_cnt = AW'(n);
    cnt = n; n_ce = 0; n_acc = 0; n_done = 0;
    first_valid_cyc = -1; start_cyc = cyc; start_flag = 1;
    step();
    i_start = 0; start_flag = 0;
  endtask

  task automatic run_to_done(input int budget, input bit rnd);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      if (rnd) i_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    chk("timeout", 32'(n_done != 0), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    rst = 1; i_start = 0; i_num_cnt = '0; i_ready = 1;
    @(posedge clk); #1;
    step();
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ce", 32'(o_ce), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    rst = 0;
    step();

    // 1: full-rate drain of 10000 pixels
    i_ready = 1;
    start(10000);
    run_to_done(10100, 0);
    chk("t1_beats", 32'(n_acc), 32'd10000);
    chk("t1_ce", 32'(n_ce), 32'd10000);
    chk("t1_first", 32'(first_valid_cyc - start_cyc), 32'd3);
    chk("t1_done_lat", 32'(done_cyc - start_cyc), 32'd10003);
    chk("t1_idle", 32'(o_idle), 32'd1);
    step(); step();
    chk("t1_one_done", 32'(n_done), 32'd1);

    // 2: random backpressure
    start(2000);
    run_to_done(8000, 1);
    chk("t2_beats", 32'(n_acc), 32'd2000);
    chk("t2_ce", 32'(n_ce), 32'd2000);
    i_ready = 1;
    step();

    // 3: empty request
    start(0);
    chk("t3_done", 32'(o_done), 32'd1);
    chk("t3_ce", 32'(o_ce), 32'd0);
    chk("t3_valid", 32'(o_valid), 32'd0);
    step(); step(); step();
    chk("t3_no_ce", 32'(n_ce), 32'd0);
    chk("t3_no_beat", 32'(n_acc), 32'd0);
    chk("t3_last", 32'(o_last), 32'd0);
    chk("t3_idle", 32'(o_idle), 32'd1);

    // 4: single pixel, latency and last
    mem[0] = 8'hA5;
    i_ready = 0;
    start(1);
    chk("t4_busy", 32'(o_busy), 32'd1);
    chk("t4_idle", 32'(o_idle), 32'd0);
    step(); step(); step();
    chk("t4_first", 32'(first_valid_cyc - start_cyc), 32'd3);
    chk("t4_data", 32'(o_data), 32'hA5);
    chk("t4_last", 32'(o_last), 32'd1);
    i_ready = 1;
    run_to_done(10, 0);
    chk("t4_beats", 32'(n_acc), 32'd1);
    mem[0] = 8'h00;
    step();

    // 5: reset at beat 50 then restart from address 0
    start(100);
    begin
      int k = 0;
      while (n_acc < 50 && k < 200) begin step(); k++; end
    end
    chk("t5_reach50", 32'(n_acc), 32'd50);
    rst = 1; i_ready = 0;
    step();
    rst = 0;
    n_ce = 0; n_acc = 0; cnt = 0;
    chk("t5_idle", 32'(o_idle), 32'd1);
    chk("t5_valid", 32'(o_valid), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_addr", 32'(o_addr), 32'd0);
    n_done = 0;
    repeat (5) step();
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_no_ce", 32'(n_ce), 32'd0);
    chk("t5_quiet", 32'(o_valid), 32'd0);
    i_ready = 1;
    start(100);
    run_to_done(200, 0);
    chk("t5_beats", 32'(n_acc), 32'd100);
    step();

`ifdef BRAM_IMAGE_READER_CHECKSUM_EN
    // 6: checksum of 100 x 0xFF, with a start pulse ignored mid-run
    for (int i = 0; i < 100; i++) mem[i] = 8'hFF;
    start(100);
    repeat (20) step();
    i_start = 1; i_num_cnt = AW'(5);
    step();
    i_start = 0;
    run_to_done(200, 0);
    chk("t6_beats", 32'(n_acc), 32'd100);
    chk("t6_checksum", 32'(o_checksum), 32'd25500);
    step(); step();
    chk("t6_hold", 32'(o_checksum), 32'd25500);
    chk("t6_one_done", 32'(n_done), 32'd1);
    for (int i = 0; i < 100; i++) mem[i] = 8'(i);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
